// File: rtl/hdmi_fetch_ctrl.sv
// Raster timing generator with a burst prefetcher that feeds pixel words from frame memory
// through a small FIFO. The fetch address and the FIFO rewind together at the start of vertical blank.
module hdmi_fetch_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int H_TOTAL    = 800,
    parameter int HS_START   = 656,
    parameter int HS_END     = 752,
    parameter int V_ACTIVE   = 480,
    parameter int V_TOTAL    = 525,
    parameter int VS_START   = 490,
    parameter int VS_END     = 492,
    parameter int BURST      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        pixclk,
    input  logic        reset,
    input  logic        enable,
    output logic        rd_req,
    output logic [18:0] rd_addr,
    input  logic        rd_ack,
    input  logic        rd_valid,
    input  logic [15:0] rd_data,
    output logic [15:0] pix_data,
    output logic        draw_area,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        underflow
);
    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(BURST + 1);
    localparam logic [18:0] FRAME_WORDS = 19'(H_ACTIVE * V_ACTIVE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_wrap, vis, hs, vs, sof, vblank;

    assign x_wrap = (int'(x_q) == H_TOTAL - 1);
    assign vis    = (int'(x_q) < H_ACTIVE) && (int'(y_q) < V_ACTIVE);
    assign hs     = (int'(x_q) >= HS_START) && (int'(x_q) < HS_END);
    assign vs     = (int'(y_q) >= VS_START) && (int'(y_q) < VS_END);
    assign sof    = (x_q == '0) && (y_q == '0);
    assign vblank = (x_q == '0) && (int'(y_q) == V_ACTIVE);

    always_comb begin
        x_d = x_wrap ? '0 : x_q + XW'(1);
        y_d = y_q;
        if (x_wrap) y_d = (int'(y_q) == V_TOTAL - 1) ? '0 : y_q + YW'(1);
    end

    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    logic          active_q;
    logic [1:0]    state_q, state_d;
    logic [18:0]   fetch_addr_q, fetch_addr_d;
    logic [18:0]   req_addr_q, req_addr_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          drop_q, drop_d;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop, starve, credit_ok;

    assign credit_ok = (int'(cnt_q) + BURST) <= FIFO_DEPTH;
    assign push      = (state_q == S_DATA) && rd_valid && !drop_q && !vblank;
    assign pop       = vis && active_q && (cnt_q != '0);
    assign starve    = vis && active_q && (cnt_q == '0);
    assign cnt_d     = cnt_q + CW'(push) - CW'(pop);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        req_addr_d   = req_addr_q;
        beat_d       = beat_q;
        drop_d       = drop_q;
        case (state_q)
            S_IDLE: begin
                if (active_q && !vblank && (fetch_addr_q < FRAME_WORDS) && credit_ok) begin
                    state_d    = S_REQ;
                    req_addr_d = fetch_addr_q;
                end
            end
            S_REQ: begin
                if (rd_ack) begin
                    state_d = S_DATA;
                    beat_d  = '0;
                    if (!drop_q) fetch_addr_d = fetch_addr_q + 19'(BURST);
                end
            end
            S_DATA: begin
                if (rd_valid) begin
                    beat_d = beat_q + BW'(1);
                    if (int'(beat_q) == BURST - 1) begin
                        state_d = S_IDLE;
                        drop_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A burst still in flight at the rewind belongs to the old frame: finish it, keep none of it.
        if (vblank) begin
            fetch_addr_d = '0;
            drop_d       = (state_d != S_IDLE);
        end
    end

    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            active_q     <= 1'b0;
            state_q      <= S_IDLE;
            fetch_addr_q <= '0;
            req_addr_q   <= '0;
            beat_q       <= '0;
            drop_q       <= 1'b0;
        end else begin
            if (vblank) active_q <= enable;
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= req_addr_d;
            beat_q       <= beat_d;
            drop_q       <= drop_d;
        end
    end

    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (vblank) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge pixclk) begin
        if (push) mem_q[wr_ptr_q] <= rd_data;
    end

    logic        draw_q, hs_q, vs_q, sof_q, under_q;
    logic [15:0] pix_q;

    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            draw_q  <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            sof_q   <= 1'b0;
            pix_q   <= '0;
            under_q <= 1'b0;
        end else begin
            draw_q <= vis;
            hs_q   <= hs;
            vs_q   <= vs;
            sof_q  <= sof;
            pix_q  <= pop ? mem_q[rd_ptr_q] : 16'h0000;
            if (starve) under_q <= 1'b1;
        end
    end

    assign rd_req      = (state_q == S_REQ);
    assign rd_addr     = req_addr_q;
    assign pix_data    = pix_q;
    assign draw_area   = draw_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = sof_q;
    assign underflow   = under_q;
endmodule

// File: tb/tb_hdmi_fetch_ctrl.sv
// Directed bench for hdmi_fetch_ctrl on a shrunken raster (20x8 total, 8x4 visible) so frames stay short.
module tb_hdmi_fetch_ctrl;
    localparam int HA = 8, HT = 20, HSS = 10, HSE = 14;
    localparam int VA = 4, VT = 8, VSS = 5, VSE = 6;
    localparam int BL = 4, FD = 16;
    localparam int FR = HT * VT;

    logic        pixclk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        rd_ack = 1'b0;
    logic        rd_valid = 1'b0;
    logic [15:0] rd_data = '0;
    logic        rd_req;
    logic [18:0] rd_addr;
    logic [15:0] pix_data;
    logic        draw_area, hsync, vsync, frame_start, underflow;

    always #20 pixclk = ~pixclk;

    hdmi_fetch_ctrl #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_END(HSE),
        .V_ACTIVE(VA), .V_TOTAL(VT), .VS_START(VSS), .VS_END(VSE),
        .BURST(BL), .FIFO_DEPTH(FD)
    ) dut (
        .pixclk(pixclk), .reset(reset), .enable(enable),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .pix_data(pix_data),
        .draw_area(draw_area), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .underflow(underflow)
    );

    int total = 0, bad = 0;
    int k = 0, p = 0;
    int pix_mode = 0, seq_n = 0, starved = 0, nz_out = 0;
    int req_cnt = 0, first_req = -1, first_addr = -1;

    // Arbiter model: ack after ack_delay cycles, then BL back-to-back beats whose data is the address.
    int ack_delay = 0, cur_delay = 0, wait_cnt = 0, beats_left = 0, acks = 0;
    bit waiting = 1'b0;
    logic [18:0] base = '0;
    initial forever begin
        @(posedge pixclk); #1;
        rd_ack = 1'b0;
        rd_valid = 1'b0;
        if (beats_left > 0) begin
            rd_valid = 1'b1;
            rd_data = 16'(base + 19'(BL - beats_left));
            beats_left--;
        end else if (rd_req) begin
            if (!waiting) begin
                waiting = 1'b1;
                cur_delay = ack_delay;
                wait_cnt = 0;
            end
            if (wait_cnt >= cur_delay) begin
                rd_ack = 1'b1;
                base = rd_addr;
                beats_left = BL;
                waiting = 1'b0;
                acks++;
            end else wait_cnt++;
        end else waiting = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic int exp_pix(input int pp);
        int q;
        q = pp % FR;
        return (q / HT) * HA + (q % HT);
    endfunction

    task automatic tick();
        @(posedge pixclk); #2;
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            p = k - 1;
            if (p % FR == 0) seq_n = 0;
            if (rd_req) begin
                req_cnt++;
                if (first_req < 0) begin
                    first_req = p;
                    first_addr = int'(rd_addr);
                end
            end
            if (draw_area) begin
                case (pix_mode)
                    1: chk($sformatf("pix_exact@%0d", p), pix_data, exp_pix(p));
                    2: chk($sformatf("pix_blank@%0d", p), pix_data, 0);
                    3: begin
                        if (pix_data == 16'(seq_n)) seq_n++;
                        else if (pix_data == 16'h0000) starved++;
                        else chk($sformatf("pix_order@%0d", p), pix_data, seq_n);
                    end
                    default: ;
                endcase
            end else if (pix_data != 16'h0000) nz_out++;
        end
    endtask

    typedef struct {
        int         p;
        logic [3:0] e;   // {draw_area, hsync, vsync, frame_start}
    } vec_t;
    vec_t tv [16];

    initial begin
        int vi, hs_cnt, vs_cnt, draw_cnt, fs_cnt, fs_prev, fs_gap, guard, nb;
        tv[0]  = '{p: 0,   e: 4'b1001};
        tv[1]  = '{p: 7,   e: 4'b1000};
        tv[2]  = '{p: 8,   e: 4'b0000};
        tv[3]  = '{p: 10,  e: 4'b0100};
        tv[4]  = '{p: 13,  e: 4'b0100};
        tv[5]  = '{p: 14,  e: 4'b0000};
        tv[6]  = '{p: 19,  e: 4'b0000};
        tv[7]  = '{p: 20,  e: 4'b1000};
        tv[8]  = '{p: 67,  e: 4'b1000};
        tv[9]  = '{p: 68,  e: 4'b0000};
        tv[10] = '{p: 80,  e: 4'b0000};
        tv[11] = '{p: 100, e: 4'b0010};
        tv[12] = '{p: 110, e: 4'b0110};
        tv[13] = '{p: 120, e: 4'b0000};
        tv[14] = '{p: 160, e: 4'b1001};
        tv[15] = '{p: 170, e: 4'b0100};

        // Reset state, then two frames of pure timing with enable low.
        repeat (3) @(posedge pixclk);
        #3;
        chk("rst_req", rd_req, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_pix", pix_data, 0);
        chk("rst_flags", {draw_area, hsync, vsync, frame_start, underflow}, 0);
        @(negedge pixclk);
        reset = 1'b1;
        k = 0;
        vi = 0; hs_cnt = 0; vs_cnt = 0; draw_cnt = 0; fs_cnt = 0; fs_prev = -1; fs_gap = 0;
        for (int c = 0; c < 2 * FR; c++) begin
            tick();
            p = k - 1;
            if (hsync) hs_cnt++;
            if (vsync) vs_cnt++;
            if (draw_area) draw_cnt++;
            if (rd_req) req_cnt++;
            if (pix_data != 16'h0000) nz_out++;
            if (frame_start) begin
                if (fs_prev >= 0) fs_gap = p - fs_prev;
                fs_prev = p;
                fs_cnt++;
            end
            if (vi < 16 && tv[vi].p == p) begin
                chk($sformatf("timing_p%0d", p), {draw_area, hsync, vsync, frame_start}, tv[vi].e);
                vi++;
            end
        end
        chk("hs_cycles", hs_cnt, 2 * VT * (HSE - HSS));
        chk("vs_cycles", vs_cnt, 2 * HT * (VSE - VSS));
        chk("draw_cycles", draw_cnt, 2 * HA * VA);
        chk("fs_count", fs_cnt, 2);
        chk("fs_period", fs_gap, FR);
        chk("req_disabled", req_cnt, 0);

        // Enable mid-frame: prefetch begins right after the next vertical blank, frames display 0..31.
        enable = 1'b1;
        run(160);
        pix_mode = 1;
        run(80);
        chk("acks_frame1", acks, 8);
        run(160);
        chk("acks_frame2", acks, 16);
        run(80);
        chk("first_req_p", first_req, 401);
        chk("first_req_addr", first_addr, 0);
        chk("no_underflow", underflow, 0);

        // Drop enable mid-frame: this frame completes, the next one is blank with no requests.
        run(10);
        enable = 1'b0;
        run(70);
        req_cnt = 0;
        run(80);
        pix_mode = 2;
        run(160);
        chk("req_after_disable", req_cnt, 0);
        chk("acks_total", acks, 24);
        chk("no_underflow2", underflow, 0);

        // Starve line 0 with a slow ack: zeros appear in place, order holds, underflow sticks.
        enable = 1'b1;
        pix_mode = 0;
        run(160);
        ack_delay = 40;
        pix_mode = 3;
        run(20);
        ack_delay = 0;
        run(140);
        chk("starved_any", (starved > 0), 1);
        chk("starve_slots", seq_n + starved, HA * VA);
        chk("underflow_set", underflow, 1);
        pix_mode = 1;
        run(160);
        chk("underflow_sticky", underflow, 1);

        // Reset while a request is pending: rd_req falls without a clock edge.
        ack_delay = 1000;
        guard = 0;
        while (!rd_req && guard < 200) begin
            run(1);
            guard++;
        end
        chk("req_pending_seen", rd_req, 1);
        #5;
        reset = 1'b0;
        #1;
        chk("async_req_drop", rd_req, 0);
        chk("async_flags", {draw_area, hsync, vsync, frame_start, underflow}, 0);
        chk("async_pix", pix_data, 0);
        ack_delay = 0;
        repeat (2) @(posedge pixclk);
        @(negedge pixclk);
        reset = 1'b1;
        k = 0;
        pix_mode = 2;
        run(1);
        chk("fs_after_release", frame_start, 1);

        // Reset after 3 of 4 beats are taken; remaining beats arrive late and must be ignored.
        nb = 0;
        guard = 0;
        while (nb < 4 && guard < 300) begin
            run(1);
            if (rd_valid) nb++;
            guard++;
        end
        chk("beats_seen", nb, 4);
        #5;
        reset = 1'b0;
        #1;
        chk("mid_burst_req", rd_req, 0);
        chk("mid_burst_addr", rd_addr, 0);
        repeat (2) @(posedge pixclk);
        @(negedge pixclk);
        reset = 1'b1;
        k = 0;
        first_req = -1;
        run(160);
        chk("restart_req_p", first_req, 81);
        chk("restart_req_addr", first_addr, 0);
        pix_mode = 1;
        run(160);
        chk("restart_no_underflow", underflow, 0);
        chk("pix_outside_zero", nz_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
